// File: rtl/rms_norm_seq_pkg.sv
// Shared fixed-point definitions for the RMS-norm sequencer and its arithmetic neighbours.
package rms_norm_seq_pkg;

  localparam int N       = 22;
  localparam int Q       = 10;
  localparam int MAX_LEN = 64;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef logic signed [N-1:0] fixed_t;

  localparam fixed_t FIX_MAX = fixed_t'({1'b0, {(N-1){1'b1}}});
  localparam fixed_t FIX_MIN = fixed_t'({1'b1, {(N-1){1'b0}}});
  localparam fixed_t FIX_ONE = fixed_t'(1 << Q);

  // Element count expressed as a Q-format value, used as the divider's divisor.
  function automatic fixed_t len_to_fix(input logic [LW-1:0] l);
    return fixed_t'({{(N-LW){1'b0}}, l} << Q);
  endfunction

endpackage

// File: rtl/rms_norm_seq_sq_acc.sv
// Saturating square-and-accumulate: sum += (x*x)>>>Q, both stages clamp at FIX_MAX.
module rms_sq_acc
  import rms_norm_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_clear,
  input  logic   i_en,
  input  fixed_t i_data,
  output fixed_t o_sum,
  output logic   o_ovf
);

  logic signed [2*N-1:0] w_prod;
  logic signed [2*N-1:0] w_shift;
  logic                  w_sq_sat;
  logic [N-1:0]          w_sq;
  logic [N:0]            w_add;
  logic                  w_add_sat;
  fixed_t                w_next;
  fixed_t                r_sum;
  logic                  r_ovf;

  assign w_prod  = i_data * i_data;
  assign w_shift = w_prod >>> Q;

  // The square is never negative, so any bit at or above the sign position means saturation.
  assign w_sq_sat  = |w_shift[2*N-1:N-1];
  assign w_sq      = w_sq_sat ? FIX_MAX : w_shift[N-1:0];
  assign w_add     = {1'b0, r_sum} + {1'b0, w_sq};
  assign w_add_sat = w_add[N] | w_add[N-1];
  assign w_next    = w_add_sat ? FIX_MAX : fixed_t'(w_add[N-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_next;
      r_ovf <= r_ovf | w_sq_sat | w_add_sat;
    end
  end

  assign o_sum = r_sum;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/rms_norm_seq.sv
// RMS of a streamed Q-format vector; drives the shared divider and sqrt units over start/busy/done.
//   state      | meaning
//   S_IDLE     | waiting for start, result held
//   S_ACCUM    | accepting len elements into square-accumulator
//   S_DIV_REQ  | request divide once divider is idle
//   S_DIV_WAIT | waiting for quotient (mean)
//   S_SQRT_REQ | request sqrt once sqrt unit is idle
//   S_SQRT_WAIT| waiting for root
//   S_DONE     | one-cycle done pulse
module rms_norm_seq
  import rms_norm_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          data_valid,
  input  fixed_t        data_in,
  output logic          data_ready,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output fixed_t        rms_q,
  output logic          div_start,
  output fixed_t        div_dividend,
  output fixed_t        div_divisor,
  input  logic          div_busy,
  input  logic          div_done,
  input  logic          div_overflow,
  input  fixed_t        div_q,
  output logic          sqrt_start,
  output fixed_t        sqrt_rad_q,
  input  logic          sqrt_busy,
  input  logic          sqrt_done,
  input  logic          sqrt_neg_rad,
  input  fixed_t        sqrt_root_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_DIV_REQ, S_DIV_WAIT, S_SQRT_REQ, S_SQRT_WAIT, S_DONE
  } state_t;

  state_t        r_state, w_next_state;
  logic [LW-1:0] r_len, r_cnt;
  fixed_t        r_mean, r_rms, w_sum;
  logic          r_ovf, w_acc_ovf;
  logic          w_start_acc, w_accept, w_last;

  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_accept    = data_valid && data_ready;
  assign w_last      = w_accept && (r_cnt == r_len - LW'(1));

  rms_sq_acc u_sq_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start_acc),
    .i_en    (w_accept),
    .i_data  (data_in),
    .o_sum   (w_sum),
    .o_ovf   (w_acc_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next_state = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM:     if (w_last) w_next_state = S_DIV_REQ;
      S_DIV_REQ:   if (!div_busy) w_next_state = S_DIV_WAIT;
      S_DIV_WAIT:  if (div_done) w_next_state = S_SQRT_REQ;
      S_SQRT_REQ:  if (!sqrt_busy) w_next_state = S_SQRT_WAIT;
      S_SQRT_WAIT: if (sqrt_done) w_next_state = S_DONE;
      S_DONE:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    data_ready = (r_state == S_ACCUM);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    div_start  = (r_state == S_DIV_REQ) && !div_busy;
    sqrt_start = (r_state == S_SQRT_REQ) && !sqrt_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_mean <= '0;
      r_rms  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_len  <= len;
        r_cnt  <= '0;
        r_mean <= '0;
        r_rms  <= '0;
        r_ovf  <= 1'b0;
      end
      if (w_accept) r_cnt <= r_cnt + LW'(1);
      if (r_state == S_DIV_WAIT && div_done) begin
        r_mean <= div_q;
        r_ovf  <= r_ovf | div_overflow;
      end
      // A negative radicand is impossible for a mean of squares; treat it as a fault.
      if (r_state == S_SQRT_WAIT && sqrt_done) begin
        r_rms <= sqrt_neg_rad ? '0 : sqrt_root_q;
        if (sqrt_neg_rad) r_ovf <= 1'b1;
      end
    end
  end

  assign overflow     = r_ovf | w_acc_ovf;
  assign rms_q        = r_rms;
  assign div_dividend = w_sum;
  assign div_divisor  = len_to_fix(r_len);
  assign sqrt_rad_q   = r_mean;

endmodule

// File: tb/tb_rms_norm_seq.sv
// Bench for rms_norm_seq: divider/sqrt behavioural units with random latency, arithmetic reference model.
module tb_rms_norm_seq;
  import rms_norm_seq_pkg::*;

  localparam longint FMAX = (longint'(1) << (N-1)) - 1;

  logic          clk, rst_n, start, data_valid;
  logic [LW-1:0] len;
  fixed_t        data_in;
  logic          data_ready, busy, done, overflow, div_start, sqrt_start;
  fixed_t        rms_q, div_dividend, div_divisor, sqrt_rad_q;
  logic          div_busy, div_busy_b, div_done, div_overflow, r_hold;
  fixed_t        div_q;
  logic          sqrt_busy, sqrt_done, sqrt_neg_rad;
  fixed_t        sqrt_root_q;

  int     total = 0, bad = 0;
  int     n_div = 0, n_sqrt = 0, unstable = 0, epoch = 0;
  bit     r_neg = 0;
  fixed_t obs_dividend, obs_divisor, obs_rad;
  int     vec [64];

  assign div_busy = div_busy_b | r_hold;

  rms_norm_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .busy(busy), .done(done), .overflow(overflow), .rms_q(rms_q),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done), .div_overflow(div_overflow), .div_q(div_q),
    .sqrt_start(sqrt_start), .sqrt_rad_q(sqrt_rad_q), .sqrt_busy(sqrt_busy),
    .sqrt_done(sqrt_done), .sqrt_neg_rad(sqrt_neg_rad), .sqrt_root_q(sqrt_root_q)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic longint isqrt(input longint v);
    longint lo = 0, hi = longint'(1) << 32, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Divider: Q-format quotient (a<<Q)/b, saturating, 1..20 cycles after the request.
  initial begin : div_unit
    int lat, ep;
    longint q;
    div_busy_b = 0; div_done = 0; div_overflow = 0; div_q = '0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1 && rst_n === 1'b1) begin
        n_div++;
        ep = epoch;
        obs_dividend = div_dividend;
        obs_divisor  = div_divisor;
        lat = $urandom_range(1, 20);
        @(negedge clk);
        div_busy_b = 1;
        repeat (lat - 1) @(negedge clk);
        if (obs_divisor == 0) q = FMAX + 1;
        else q = (longint'(obs_dividend) * 1024) / longint'(obs_divisor);
        div_overflow = (q > FMAX);
        div_q = fixed_t'((q > FMAX) ? FMAX : q);
        div_done = 1;
        if (ep == epoch && (div_dividend !== obs_dividend || div_divisor !== obs_divisor)) unstable++;
        @(negedge clk);
        div_done = 0; div_busy_b = 0; div_overflow = 0;
      end
    end
  end

  // Square root: floor(sqrt(rad<<Q)), 1..20 cycles after the request.
  initial begin : sqrt_unit
    int lat, ep;
    sqrt_busy = 0; sqrt_done = 0; sqrt_neg_rad = 0; sqrt_root_q = '0;
    forever begin
      @(negedge clk);
      if (sqrt_start === 1'b1 && rst_n === 1'b1) begin
        n_sqrt++;
        ep = epoch;
        obs_rad = sqrt_rad_q;
        lat = $urandom_range(1, 20);
        @(negedge clk);
        sqrt_busy = 1;
        repeat (lat - 1) @(negedge clk);
        sqrt_root_q  = r_neg ? fixed_t'(12345) : fixed_t'(isqrt(longint'(obs_rad) * 1024));
        sqrt_neg_rad = r_neg;
        sqrt_done = 1;
        if (ep == epoch && sqrt_rad_q !== obs_rad) unstable++;
        @(negedge clk);
        sqrt_done = 0; sqrt_busy = 0; sqrt_neg_rad = 0;
      end
    end
  end

  function automatic void model(input int l, output longint s, output longint m,
                                output longint r, output bit o);
    longint sq;
    s = 0; m = 0; r = 0; o = 0;
    for (int i = 0; i < l; i++) begin
      sq = (longint'(vec[i]) * longint'(vec[i])) >>> 10;
      if (sq > FMAX) begin sq = FMAX; o = 1; end
      s = s + sq;
      if (s > FMAX) begin s = FMAX; o = 1; end
    end
    if (l != 0) begin
      m = (s * 1024) / (longint'(l) * 1024);
      if (m > FMAX) begin m = FMAX; o = 1; end
      r = isqrt(m * 1024);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string nm, input int l, input bit hold, input bit gaps);
    longint e_sum, e_mean, e_root;
    bit     e_ovf, got, rdy_seen;
    int     d0, s0, u0;
    model(l, e_sum, e_mean, e_root, e_ovf);
    if (r_neg) begin e_root = 0; e_ovf = 1; end
    d0 = n_div; s0 = n_sqrt; u0 = unstable;
    r_hold = hold;
    start = 1; len = LW'(l);
    tick();
    start = 0;
    chk({nm, "_busy"}, busy, 1);
    if (l == 0) begin
      chk({nm, "_done"}, done, 1);
      chk({nm, "_rms"}, $signed(rms_q), 0);
      chk({nm, "_ovf"}, overflow, 0);
      tick();
      chk({nm, "_done_width"}, done, 0);
      chk({nm, "_idle"}, busy, 0);
      chk({nm, "_no_div"}, n_div - d0, 0);
      chk({nm, "_no_sqrt"}, n_sqrt - s0, 0);
      return;
    end
    chk({nm, "_ready_lat"}, data_ready, 1);
    for (int i = 0; i < l; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin data_valid = 0; tick(); end
      data_valid = 1; data_in = fixed_t'(vec[i]);
      tick();
    end
    data_valid = 0;
    chk({nm, "_ready_drop"}, data_ready, 0);
    chk({nm, "_dividend"}, $signed(div_dividend), e_sum);
    chk({nm, "_divisor"}, $signed(div_divisor), longint'(l) * 1024);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        chk({nm, "_div_held"}, div_start, 0);
        tick();
      end
      r_hold = 0;
      #1;
      chk({nm, "_div_release"}, div_start, 1);
    end else begin
      chk({nm, "_div_lat"}, div_start, 1);
    end
    got = 0; rdy_seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (done === 1'b1) begin got = 1; break; end
      if (data_ready !== 1'b0) rdy_seen = 1;
      data_valid = 1'($urandom_range(0, 1));
      data_in = fixed_t'($urandom);
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 0; data_valid = 0;
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_ready_low_wait"}, rdy_seen, 0);
    chk({nm, "_rms"}, $signed(rms_q), e_root);
    chk({nm, "_ovf"}, overflow, e_ovf);
    chk({nm, "_div_op_a"}, $signed(obs_dividend), e_sum);
    chk({nm, "_rad"}, $signed(obs_rad), e_mean);
    chk({nm, "_one_div"}, n_div - d0, 1);
    chk({nm, "_one_sqrt"}, n_sqrt - s0, 1);
    chk({nm, "_stable"}, unstable - u0, 0);
    tick();
    chk({nm, "_done_width"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_rms_hold"}, $signed(rms_q), e_root);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ready"}, data_ready, 0);
    chk({nm, "_ovf"}, overflow, 0);
    chk({nm, "_rms"}, $signed(rms_q), 0);
    chk({nm, "_dstart"}, div_start, 0);
    chk({nm, "_sstart"}, sqrt_start, 0);
    chk({nm, "_dividend"}, $signed(div_dividend), 0);
    chk({nm, "_divisor"}, $signed(div_divisor), 0);
    chk({nm, "_rad"}, $signed(sqrt_rad_q), 0);
  endtask

  initial begin : main
    int l;
    bit ok;
    rst_n = 0; start = 0; len = '0; data_valid = 0; data_in = '0; r_hold = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    tick();

    for (int i = 0; i < 4; i++) vec[i] = 1024;
    run_job("t1", 4, 0, 0);

    vec[0] = 3072; vec[1] = -4096;
    run_job("t2", 2, 0, 1);
    chk("t2_rms_const", $signed(rms_q), 3620);

    vec[0] = 2097151;
    run_job("t3", 1, 0, 0);
    chk("t3_ovf_const", overflow, 1);

    run_job("t4", 0, 0, 0);

    for (int i = 0; i < 4; i++) vec[i] = 1024;
    run_job("t5", 4, 1, 0);

    // Abort mid-divide; the stale divider completion must be ignored.
    start = 1; len = LW'(4);
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin data_valid = 1; data_in = fixed_t'(1024); tick(); end
    data_valid = 0;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      if (div_busy_b === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk("t6_reached_wait", ok, 1);
    rst_n = 0; epoch++;
    #1;
    chk_zero("t6_abort");
    tick();
    rst_n = 1;
    for (int c = 0; c < 40 && div_busy_b !== 1'b0; c++) tick();
    tick();
    run_job("t6_after", 4, 0, 0);

    r_neg = 1;
    vec[0] = 2048; vec[1] = 1024;
    run_job("negrad", 2, 0, 0);
    r_neg = 0;

    for (int j = 0; j < 10; j++) begin
      l = $urandom_range(1, 12);
      for (int i = 0; i < l; i++) begin
        if ($urandom_range(0, 7) == 0) vec[i] = int'(fixed_t'($urandom));
        else vec[i] = int'($urandom_range(0, 16383)) - 8192;
      end
      run_job($sformatf("rnd%0d", j), l, 0, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 64; i++) vec[i] = int'($urandom_range(0, 131071)) - 65536;
    run_job("maxlen", 64, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
